// File: rtl/console_mux_pkg.sv
// rtl/console_mux_pkg.sv - shared hexbus constants and arbiter state encoding
package hbconst;

  localparam logic [6:0] NEWLINE = 7'h0a;
  localparam int         TAG_BIT = 7;

  typedef enum logic {
    IDLE   = 1'b0,
    HBLOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/console_mux_if.sv
// rtl/console_mux_if.sv - UART / hexbus / console byte streams around console_mux
interface console_mux_if;

  logic       i_rx_stb;
  logic [7:0] i_rx_byte;
  logic       o_hb_stb;
  logic [6:0] o_hb_byte;
  logic       o_rxcon_stb;
  logic [6:0] o_rxcon_data;
  logic       i_hb_stb;
  logic [6:0] i_hb_byte;
  logic       o_hb_busy;
  logic       i_txcon_stb;
  logic [6:0] i_txcon_data;
  logic       o_txcon_busy;
  logic       o_tx_stb;
  logic [7:0] o_tx_byte;
  logic       i_tx_busy;

  modport slave (
    input  i_rx_stb, i_rx_byte, i_hb_stb, i_hb_byte, i_txcon_stb, i_txcon_data, i_tx_busy,
    output o_hb_stb, o_hb_byte, o_rxcon_stb, o_rxcon_data, o_hb_busy, o_txcon_busy,
           o_tx_stb, o_tx_byte
  );

  modport master (
    output i_rx_stb, i_rx_byte, i_hb_stb, i_hb_byte, i_txcon_stb, i_txcon_data, i_tx_busy,
    input  o_hb_stb, o_hb_byte, o_rxcon_stb, o_rxcon_data, o_hb_busy, o_txcon_busy,
           o_tx_stb, o_tx_byte
  );

endinterface

// File: rtl/console_txarb.sv
// rtl/console_txarb.sv - tx arbiter: packet lock FSM, idle release counter, output register
module console_txarb
  import hbconst::*;
#(
  parameter int LGIDLE = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       hb_stb,
  input  logic [6:0] hb_byte,
  input  logic       txcon_stb,
  input  logic [6:0] txcon_data,
  input  logic       tx_busy,
  output logic       hb_busy,
  output logic       txcon_busy,
  output logic       tx_stb,
  output logic [7:0] tx_byte
);

  localparam logic [LGIDLE-1:0] IDLE_MAX = '1;

  arb_state_t        state, state_next;
  logic [LGIDLE-1:0] idle_cnt, idle_cnt_next;
  logic              last_con;
  logic              load, grant_hb, grant_con, accept_hb, accept_con;

  always_comb begin
    load      = !tx_stb || !tx_busy;
    grant_hb  = 1'b0;
    grant_con = 1'b0;
    if (state == HBLOCK) begin
      grant_hb = hb_stb;
    end else if (hb_stb && txcon_stb) begin
      grant_hb  = last_con;
      grant_con = !last_con;
    end else begin
      grant_hb  = hb_stb;
      grant_con = txcon_stb;
    end
    accept_hb  = load && grant_hb;
    accept_con = load && grant_con;
    hb_busy    = !load || !grant_hb;
    txcon_busy = !load || !grant_con;

    state_next    = state;
    idle_cnt_next = '0;
    case (state)
      IDLE: begin
        if (accept_hb && hb_byte != NEWLINE)
          state_next = HBLOCK;
      end
      HBLOCK: begin
        // An abandoned packet must not starve the console forever
        if (accept_hb) begin
          if (hb_byte == NEWLINE)
            state_next = IDLE;
        end else begin
          idle_cnt_next = idle_cnt + 1'b1;
          if (idle_cnt_next == IDLE_MAX)
            state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      idle_cnt <= '0;
      last_con <= 1'b0;
      tx_stb   <= 1'b0;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_cnt_next;
      if (accept_con)
        last_con <= 1'b1;
      else if (accept_hb)
        last_con <= 1'b0;
      if (load)
        tx_stb <= accept_hb || accept_con;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept_hb || accept_con)
      tx_byte <= accept_hb ? {1'b1, hb_byte} : {1'b0, txcon_data};
  end

endmodule

// File: rtl/console_mux.sv
// rtl/console_mux.sv - splits/merges the host UART between hexbus and console by bit 7
module console_mux
  import hbconst::*;
#(
  parameter int LGIDLE = 10
) (
  input logic          i_clk,
  input logic          i_reset,
  console_mux_if.slave bus
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_hb_stb    <= 1'b0;
      bus.o_rxcon_stb <= 1'b0;
    end else begin
      bus.o_hb_stb    <= bus.i_rx_stb && bus.i_rx_byte[TAG_BIT];
      bus.o_rxcon_stb <= bus.i_rx_stb && !bus.i_rx_byte[TAG_BIT];
    end
  end

  always_ff @(posedge i_clk) begin
    if (bus.i_rx_stb) begin
      bus.o_hb_byte    <= bus.i_rx_byte[6:0];
      bus.o_rxcon_data <= bus.i_rx_byte[6:0];
    end
  end

  console_txarb #(.LGIDLE(LGIDLE)) u_txarb (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .hb_stb     (bus.i_hb_stb),
    .hb_byte    (bus.i_hb_byte),
    .txcon_stb  (bus.i_txcon_stb),
    .txcon_data (bus.i_txcon_data),
    .tx_busy    (bus.i_tx_busy),
    .hb_busy    (bus.o_hb_busy),
    .txcon_busy (bus.o_txcon_busy),
    .tx_stb     (bus.o_tx_stb),
    .tx_byte    (bus.o_tx_byte)
  );

endmodule

// File: tb/tb_console_mux.sv
// tb/tb_console_mux.sv - randomized scoreboard bench for console_mux
module tb_console_mux;
  import hbconst::*;

  localparam int LG  = 3;
  localparam int GAP = 1 << LG;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  console_mux_if bus();

  console_mux #(.LGIDLE(LG)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int compared = 0;
  int mismatched = 0;

  logic [6:0] hb_src[$], con_src[$], exp_rx_hb[$], exp_rx_con[$];
  logic [7:0] exp_tx_hb[$], exp_tx_con[$], tx_log[$], rx_script[$];
  bit         con_ok_q[$];

  bit   hb_acc = 0, con_acc = 0, pkt_open = 0, rx_on = 0, mon_en = 0, last_src_con = 0;
  bit   rst_req = 1;
  int   cyc = 0, last_hb_cyc = 0, last_con_cyc = 0, gate_pct = 100, busy_pct = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: account last cycle's handshakes, drive new inputs, sample handshakes
  task automatic step();
    logic [6:0] b;
    logic [7:0] r;
    @(negedge clk);
    if (hb_acc) begin
      b = hb_src.pop_front();
      exp_tx_hb.push_back({1'b1, b});
      pkt_open     = (b != NEWLINE);
      last_hb_cyc  = cyc;
      last_src_con = 0;
    end
    if (con_acc) begin
      b = con_src.pop_front();
      exp_tx_con.push_back({1'b0, b});
      con_ok_q.push_back(!pkt_open || (cyc - last_hb_cyc >= GAP));
      last_con_cyc = cyc;
      last_src_con = 1;
    end
    rst = rst_req;
    if (!(bus.i_hb_stb && !hb_acc)) begin
      if (hb_src.size() > 0 && $urandom_range(99) < gate_pct) begin
        bus.i_hb_stb  = 1'b1;
        bus.i_hb_byte = hb_src[0];
      end else begin
        bus.i_hb_stb  = 1'b0;
        bus.i_hb_byte = 7'($urandom);
      end
    end
    if (!(bus.i_txcon_stb && !con_acc)) begin
      if (con_src.size() > 0 && $urandom_range(99) < gate_pct) begin
        bus.i_txcon_stb  = 1'b1;
        bus.i_txcon_data = con_src[0];
      end else begin
        bus.i_txcon_stb  = 1'b0;
        bus.i_txcon_data = 7'($urandom);
      end
    end
    bus.i_rx_stb = 1'b0;
    if (rx_script.size() > 0 || (rx_on && $urandom_range(99) < 35)) begin
      r = (rx_script.size() > 0) ? rx_script.pop_front() : 8'($urandom);
      bus.i_rx_stb  = 1'b1;
      bus.i_rx_byte = r;
      if (r[7]) exp_rx_hb.push_back(r[6:0]);
      else      exp_rx_con.push_back(r[6:0]);
    end
    bus.i_tx_busy = ($urandom_range(99) < busy_pct);
    #1;
    hb_acc  = bus.i_hb_stb && !bus.o_hb_busy;
    con_acc = bus.i_txcon_stb && !bus.o_txcon_busy;
    cyc++;
  endtask

  task automatic drain(input string name);
    int quiet = 0;
    int n = 0;
    rx_on = 0; busy_pct = 0; gate_pct = 100;
    while (quiet < 3 && n < 300) begin
      step();
      n++;
      if (hb_src.size() == 0 && con_src.size() == 0 && !bus.o_tx_stb) quiet++;
      else quiet = 0;
    end
    chk(name, 32'(quiet), 32'd3);
  endtask

  bit         prev_hold = 0;
  logic [7:0] prev_byte;

  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      if (bus.o_hb_stb || bus.o_rxcon_stb)
        chk("rx_exclusive", 32'(bus.o_hb_stb && bus.o_rxcon_stb), 32'd0);
      if (bus.o_hb_stb) begin
        if (exp_rx_hb.size() == 0) chk("rx_hb_unexpected", 32'(bus.o_hb_stb), 32'd0);
        else chk("rx_hb_byte", 32'(bus.o_hb_byte), 32'(exp_rx_hb.pop_front()));
      end
      if (bus.o_rxcon_stb) begin
        if (exp_rx_con.size() == 0) chk("rx_con_unexpected", 32'(bus.o_rxcon_stb), 32'd0);
        else chk("rx_con_byte", 32'(bus.o_rxcon_data), 32'(exp_rx_con.pop_front()));
      end
      if (prev_hold) begin
        chk("tx_hold_stb", 32'(bus.o_tx_stb), 32'd1);
        chk("tx_hold_byte", 32'(bus.o_tx_byte), 32'(prev_byte));
      end
      if (bus.o_tx_stb && bus.i_tx_busy)
        chk("bp_busy", 32'({bus.o_hb_busy, bus.o_txcon_busy}), 32'd3);
      if (bus.o_tx_stb && !bus.i_tx_busy) begin
        tx_log.push_back(bus.o_tx_byte);
        if (bus.o_tx_byte[7]) begin
          if (exp_tx_hb.size() == 0) chk("tx_hb_unexpected", 32'(bus.o_tx_stb), 32'd0);
          else chk("tx_hb_byte", 32'(bus.o_tx_byte), 32'(exp_tx_hb.pop_front()));
        end else begin
          if (exp_tx_con.size() == 0) chk("tx_con_unexpected", 32'(bus.o_tx_stb), 32'd0);
          else begin
            chk("tx_con_byte", 32'(bus.o_tx_byte), 32'(exp_tx_con.pop_front()));
            chk("tx_con_inside_packet", 32'(con_ok_q.pop_front()), 32'd1);
          end
        end
      end
      prev_hold = bus.o_tx_stb && bus.i_tx_busy;
      prev_byte = bus.o_tx_byte;
    end else begin
      prev_hold = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_pkt[7];
    logic [7:0] rr_exp;
    logic [6:0] b;
    int         n;
    bit         first_hb;

    bus.i_rx_stb = 0; bus.i_rx_byte = 0; bus.i_hb_stb = 0; bus.i_hb_byte = 0;
    bus.i_txcon_stb = 0; bus.i_txcon_data = 0; bus.i_tx_busy = 0;

    repeat (3) step();
    chk("reset_tx_stb", 32'(bus.o_tx_stb), 32'd0);
    chk("reset_hb_stb", 32'(bus.o_hb_stb), 32'd0);
    chk("reset_rxcon_stb", 32'(bus.o_rxcon_stb), 32'd0);
    rst_req = 0;
    step();
    mon_en = 1;

    rx_script = '{8'hC1, 8'h41};
    step();
    step();
    chk("rx1_hb_stb", 32'(bus.o_hb_stb), 32'd1);
    chk("rx1_hb_byte", 32'(bus.o_hb_byte), 32'h41);
    chk("rx1_con_stb", 32'(bus.o_rxcon_stb), 32'd0);
    step();
    chk("rx2_con_stb", 32'(bus.o_rxcon_stb), 32'd1);
    chk("rx2_con_data", 32'(bus.o_rxcon_data), 32'h41);
    chk("rx2_hb_stb", 32'(bus.o_hb_stb), 32'd0);

    for (int p = 0; p < 40; p++) begin
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        b = 7'($urandom);
        hb_src.push_back(b == NEWLINE ? 7'h55 : b);
      end
      if ($urandom_range(4) != 0) hb_src.push_back(NEWLINE);
    end
    for (int k = 0; k < 80; k++) con_src.push_back(7'($urandom));
    gate_pct = 60; busy_pct = 30; rx_on = 1;
    n = 0;
    while ((hb_src.size() > 0 || con_src.size() > 0) && n < 4000) begin
      step();
      n++;
    end
    chk("random_sources_done", 32'(hb_src.size() + con_src.size()), 32'd0);
    drain("random_drain");

    tx_log.delete();
    hb_src = '{7'h52, 7'h31, 7'h32, 7'h33, 7'h34, 7'h0a};
    step();
    con_src.push_back(7'h58);
    drain("pkt_drain");
    exp_pkt = '{8'hD2, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h8A, 8'h58};
    chk("pkt_len", 32'(tx_log.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      if (i < tx_log.size()) chk("pkt_byte", 32'(tx_log[i]), 32'(exp_pkt[i]));

    tx_log.delete();
    first_hb = last_src_con;
    for (int i = 0; i < 6; i++) begin
      hb_src.push_back(NEWLINE);
      con_src.push_back(7'h58);
    end
    drain("rr_drain");
    chk("rr_len", 32'(tx_log.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      rr_exp = (((i % 2) == 0) == first_hb) ? 8'h8A : 8'h58;
      if (i < tx_log.size()) chk("rr_byte", 32'(tx_log[i]), 32'(rr_exp));
    end

    hb_src.push_back(7'h52);
    step();
    con_src.push_back(7'h58);
    drain("idle_drain");
    chk("idle_release_gap", 32'(last_con_cyc - last_hb_cyc), 32'(GAP));

    chk("leftover_expected", 32'(exp_rx_hb.size() + exp_rx_con.size() + exp_tx_hb.size()
        + exp_tx_con.size()), 32'd0);

    mon_en = 0;
    busy_pct = 100;
    hb_src.push_back(7'h52);
    step();
    con_src.push_back(7'h58);
    step();
    chk("rst_pre_tx_stb", 32'(bus.o_tx_stb), 32'd1);
    rst_req = 1; busy_pct = 0;
    step();
    rst_req = 0;
    step();
    chk("rst_tx_stb", 32'(bus.o_tx_stb), 32'd0);
    chk("rst_con_ready", 32'(bus.o_txcon_busy), 32'd0);
    step();
    chk("rst_con_stb", 32'(bus.o_tx_stb), 32'd1);
    chk("rst_con_byte", 32'(bus.o_tx_byte), 32'h58);
    exp_tx_hb.delete(); exp_tx_con.delete(); con_ok_q.delete();
    pkt_open = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/console_mux.md
# console_mux

Byte-level multiplexer between the single host UART and two 7-bit streams: the hexbus debug channel and the console peripheral. On receive, it splits each UART byte by bit 7: bytes with bit 7 set go to the hexbus decoder, bytes with bit 7 clear go to the console receive input. On transmit, it merges console output and hexbus encoder output onto the UART, tagging each byte with bit 7. It never breaks a hexbus packet, which ends with newline 7'h0a.

## Interface
- LGIDLE, default 10: log2 of the idle cycles after which an unterminated hexbus packet lock is released.
- i_clk  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_rx_stb  in  1  UART receive strobe, one cycle per byte.
- i_rx_byte  in  8  UART receive byte.
- o_hb_stb  out  1  byte strobe to the hexbus decoder.
- o_hb_byte  out  7  byte to the hexbus decoder (i_rx_byte[6:0]).
- o_rxcon_stb  out  1  strobe to the console's i_console_stb.
- o_rxcon_data  out  7  data to the console's i_console_data.
- i_hb_stb  in  1  hexbus encoder output valid.
- i_hb_byte  in  7  hexbus encoder output byte.
- o_hb_busy  out  1  hexbus encoder must hold its byte.
- i_txcon_stb  in  1  console's o_console_stb.
- i_txcon_data  in  7  console's o_console_data.
- o_txcon_busy  out  1  to the console's i_console_busy.
- o_tx_stb  out  1  UART transmit valid.
- o_tx_byte  out  8  UART transmit byte.
- i_tx_busy  in  1  UART transmitter busy.

## Operation
- **Rx demux (registered).**
  - i_rx_stb with bit 7 = 1: o_hb_stb <= 1 and o_hb_byte <= i_rx_byte[6:0].
  - i_rx_stb with bit 7 = 0: o_rxcon_stb <= 1 and o_rxcon_data <= i_rx_byte[6:0].
  - Both strobes are otherwise 0.
  - Both strobes are never high in the same cycle.
  - There is no backpressure: downstream must accept every strobe.
- **Tx output register.**
  - The register may load when `load = !o_tx_stb || !i_tx_busy`.
  - A source byte is accepted when that source's stb is high and its busy is low.
  - An accepted byte sets o_tx_stb = 1 the next cycle.
  - Hexbus bytes are sent as {1'b1, byte}; console bytes as {1'b0, data}.
  - o_tx_stb clears when load is true and nothing is accepted.
  - o_tx_stb and o_tx_byte stay stable while o_tx_stb && i_tx_busy.
- **Arbiter FSM**, states IDLE and HBLOCK.
- **IDLE.**
  - Only one requester: it is granted.
  - Both requesting: the source not granted last is granted (round-robin flag `last_con`).
  - A granted hexbus byte other than 7'h0a moves the FSM to HBLOCK.
- **HBLOCK.**
  - Only hexbus is granted; the console is blocked.
  - Accepting hexbus byte 7'h0a returns the FSM to IDLE.
  - The idle counter resets on every hexbus acceptance and increments on every other cycle.
  - When the counter reaches 2^LGIDLE - 1, the FSM returns to IDLE.
- **Busy outputs (combinational).**
  - o_hb_busy = !load || !grant_hb.
  - o_txcon_busy = !load || !grant_con.
  - A source with stb low is never granted; busy toward it may be either value.
- **Reset values.**
  - o_hb_stb, o_rxcon_stb, o_tx_stb = 0.
  - FSM = IDLE, idle counter = 0, last_con = 0.
  - Data registers are don't-care.
  - Reset mid-transfer drops the held byte, even if the UART has not taken it.

## Timing
- Rx path latency: 1 cycle from i_rx_stb to o_hb_stb / o_rxcon_stb.
- Tx path latency: 1 cycle from acceptance to o_tx_stb.
- Sustained throughput: one byte per cycle when i_tx_busy = 0.
- Busy outputs depend combinationally on i_tx_busy, o_tx_stb, the FSM state and both stb inputs. There is no combinational path from data inputs.
- A console byte presented during HBLOCK waits, with o_txcon_busy = 1, until the FSM is back in IDLE.
- The console's requirement that a blocked byte stays stable (its stb and data held) is preserved.

## Structure
- Shared package `hbconst`: NEWLINE = 7'h0a, the tag bit position (7), and the state encoding IDLE = 1'b0, HBLOCK = 1'b1.
- Rx demux is small enough to stay inline.
- One sub-module is natural: `console_txarb`, containing the FSM, the idle counter and the output register.

## Test plan
- **Rx split:** rx bytes 8'hC1 then 8'h41 → o_hb_stb with 7'h41 on cycle 1, then o_rxcon_stb with 7'h41 on cycle 2; the other strobe stays 0.
- **Packet integrity:** hexbus sends "R1234\n" (7'h52 … 7'h0a) while the console continuously holds 7'h58 → o_tx_byte = 8'hD2 … 8'h8A with no 8'h58 between them; 8'h58 follows after the 8'h8A.
- **Round-robin:** both sources request continuously in IDLE with hexbus sending only 7'h0a → o_tx_byte alternates 8'h8A / 8'h58.
- **Backpressure:** i_tx_busy = 1 for 5 cycles with o_tx_stb = 1 → o_tx_byte stable; o_hb_busy = o_txcon_busy = 1; no byte lost or duplicated.
- **Idle release:** with LGIDLE = 3, hexbus sends 7'h52 and then stops → the FSM returns to IDLE after 7 cycles and the pending console byte is sent the next cycle.
- **Reset mid-operation:** assert i_reset while o_tx_stb = 1 and the FSM is in HBLOCK → next cycle o_tx_stb = 0, FSM = IDLE, and a console byte is accepted immediately.
